// File: rtl/wb_merge_pkg.sv
// Shared constants, FSM encoding and destination decode for the writeback merge stage.
package wb_merge_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] wa);
    return NUM_REGS'(1) << wa;
  endfunction
endpackage

// File: rtl/wb_merge_fifo.sv
// DEPTH-entry FIFO of {wa, wd} for buffered long-latency results; exposes per-entry
// valid and destination so the top can build the pending-register mask.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [REG_ADDR_W-1:0]       push_wa,
  input  logic [XLEN-1:0]             push_wd,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [REG_ADDR_W-1:0]       head_wa,
  output logic [XLEN-1:0]             head_wd,
  output logic [DEPTH-1:0]            entry_vld,
  output logic [REG_ADDR_W-1:0]       entry_wa [DEPTH]
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           cnt;
  logic [DEPTH-1:0]      vld;
  logic [REG_ADDR_W-1:0] wa_mem [DEPTH];
  logic [XLEN-1:0]       wd_mem [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr      <= rd_ptr + AW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      if (push_ok) begin
        wr_ptr      <= wr_ptr + AW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      wa_mem[wr_ptr] <= push_wa;
      wd_mem[wr_ptr] <= push_wd;
    end
  end

  assign count     = cnt;
  assign head_wa   = wa_mem[rd_ptr];
  assign head_wd   = wd_mem[rd_ptr];
  assign entry_vld = vld;
  assign entry_wa  = wa_mem;
endmodule

// File: rtl/wb_merge.sv
// Writeback merge: pipeline owns the RF write port, buffered long-latency results drain in idle slots.
// Optional starvation guard (forced drain via stall_req) enabled by WB_MERGE_STARVE_GUARD_EN.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pipe_wen,
  input  logic [REG_ADDR_W-1:0]   pipe_wa,
  input  logic [XLEN-1:0]         pipe_wd,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [REG_ADDR_W-1:0]   lu_wa,
  input  logic [XLEN-1:0]         lu_wd,
  output logic                    rf_wen,
  output logic [REG_ADDR_W-1:0]   rf_wa,
  output logic [XLEN-1:0]         rf_wd,
  output logic                    stall_req,
  output logic [NUM_REGS-1:0]     pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  logic                  full;
  logic                  empty;
  logic [REG_ADDR_W-1:0] head_wa;
  logic [XLEN-1:0]       head_wd;
  logic [DEPTH-1:0]      entry_vld;
  logic [REG_ADDR_W-1:0] entry_wa [DEPTH];
  logic                  pipe_sel;
  logic                  pop;
  logic                  push;

  // Writes to x0 are treated as idle slots so the FIFO can use them.
  assign pipe_sel = pipe_wen && (pipe_wa != '0);
  assign pop      = !pipe_sel && !empty;
  assign push     = lu_valid && lu_ready && (lu_wa != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_wa   (lu_wa),
    .push_wd   (lu_wd),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .head_wa   (head_wa),
    .head_wd   (head_wd),
    .entry_vld (entry_vld),
    .entry_wa  (entry_wa)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pending_mask = pending_mask | reg_onehot(entry_wa[i]);
    end
  end

  // Port select -> registered RF write (one cycle after the decision)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wen <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else begin
      rf_wen <= pipe_sel || pop;
      if (pipe_sel) begin
        rf_wa <= pipe_wa;
        rf_wd <= pipe_wd;
      end else if (pop) begin
        rf_wa <= head_wa;
        rf_wd <= head_wd;
      end
    end
  end

`ifdef WB_MERGE_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop || empty)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (starve_cnt == SW'(STARVE_LIMIT)) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    stall_req = (state == DRAIN);
    lu_ready  = !full && (state == NORMAL) && !reset;
  end
`else
  logic cfg_unused;

  assign cfg_unused = (STARVE_LIMIT > 0);
  assign stall_req  = 1'b0;
  assign lu_ready   = !full && !reset;
`endif
endmodule
